// File: rtl/hamming_tx.sv
// hamming_tx: serial Hamming(7,4) transmitter.
// Encodes an accepted nibble into a 7-bit codeword and sends it on one line.
// The frame is a start bit (0), then the codeword LSB first, then a stop bit (1).
// Each serial bit is held for CLKS_PER_BIT cycles.
//
// Optional build macro: HAMMING_ERR_INJECT_EN
//   When defined, err_pos_i (1..7) inverts that codeword position before sending.
//   When undefined, err_pos_i is ignored and the clean codeword is always sent.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   data_i     nibble to encode (d1 = data_i[0] .. d4 = data_i[3])
//   valid_i    data_i / err_pos_i valid
//   ready_o    idle and able to accept a nibble
//   err_pos_i  error-injection position, 0 = none
//   tx_o       serial line, idles high
//   word_o     codeword of the current or most recent frame, word_o[i-1] = position i
//   busy_o     frame in progress
//   done_o     one-cycle pulse in the last cycle of the stop bit
module hamming_tx #(
   parameter int unsigned CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] data_i,
   input  logic       valid_i,
   output logic       ready_o,
   input  logic [2:0] err_pos_i,
   output logic       tx_o,
   output logic [6:0] word_o,
   output logic       busy_o,
   output logic       done_o
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   // Second-to-last count; only used when a bit lasts at least two cycles.
   localparam logic [CNT_W-1:0] CNT_PEN  = CNT_W'(CLKS_PER_BIT - 2);
   localparam bit ONE_CYCLE = (CLKS_PER_BIT == 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [2:0]       next_idx_c;
   logic [6:0]       code_c;
   logic [6:0]       word_c;

   // Hamming(7,4) encoder: positions 1..7 = p1, p2, d1, p3, d2, d3, d4.
   always_comb begin
      logic p1, p2, p3;
      p1     = data_i[0] ^ data_i[1] ^ data_i[3];
      p2     = data_i[0] ^ data_i[2] ^ data_i[3];
      p3     = data_i[1] ^ data_i[2] ^ data_i[3];
      code_c = {data_i[3], data_i[2], data_i[1], p3, data_i[0], p2, p1};
   end

`ifdef HAMMING_ERR_INJECT_EN
   // One-hot at bit k for err_pos_i = k; bit 0 (k = 0) is dropped, giving no flip.
   logic [7:0] flip_c;
   assign flip_c = 8'd1 << err_pos_i;
   assign word_c = code_c ^ flip_c[7:1];
`else
   logic unused_err_pos;
   assign unused_err_pos = ^err_pos_i;
   assign word_c         = code_c;
`endif

   assign next_idx_c = bit_idx + 3'd1;

   // Frame sequencer; every output is a register updated alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         tx_o    <= 1'b1;
         ready_o <= 1'b1;
         busy_o  <= 1'b0;
         done_o  <= 1'b0;
         word_o  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (valid_i && ready_o) begin
                  state   <= START;
                  word_o  <= word_c;
                  tx_o    <= 1'b0;
                  ready_o <= 1'b0;
                  busy_o  <= 1'b1;
                  cnt     <= '0;
               end
            end
            START: begin
               if (cnt == CNT_LAST) begin
                  state   <= DATA;
                  cnt     <= '0;
                  bit_idx <= '0;
                  tx_o    <= word_o[0];
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DATA: begin
               if (cnt == CNT_LAST) begin
                  cnt <= '0;
                  if (bit_idx == 3'd6) begin
                     state  <= STOP;
                     tx_o   <= 1'b1;
                     // A one-cycle stop bit is also its own last cycle.
                     done_o <= ONE_CYCLE;
                  end else begin
                     bit_idx <= next_idx_c;
                     tx_o    <= word_o[next_idx_c];
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            STOP: begin
               if (cnt == CNT_LAST) begin
                  state   <= IDLE;
                  cnt     <= '0;
                  bit_idx <= '0;
                  done_o  <= 1'b0;
                  ready_o <= 1'b1;
                  busy_o  <= 1'b0;
               end else begin
                  cnt    <= cnt + 1'b1;
                  // Raise done so it is visible in the final stop cycle.
                  done_o <= (cnt == CNT_PEN);
               end
            end
            default: begin
               state   <= IDLE;
               cnt     <= '0;
               bit_idx <= '0;
               tx_o    <= 1'b1;
               ready_o <= 1'b1;
               busy_o  <= 1'b0;
               done_o  <= 1'b0;
            end
         endcase
      end
   end

endmodule
